// File: rtl/jtkunio_bram_ba_pkg.sv
// Shared types and constants for the BRAM-backed SDRAM bank responder.
// JTKUNIO_BA_RR_EN selects round-robin bank arbitration.
package jtkunio_bram_ba_pkg;

    localparam int NBANK = 4;
    localparam int DW    = 16;
    localparam int CAW   = 22;

    typedef enum logic [2:0] {
        IDLE,
        BREAD,
        PWR,
        PRD,
        WAIT
    } state_t;

    function automatic logic [1:0] onehot_idx(input logic [NBANK-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int k = 0; k < NBANK; k++) begin
            if (oh[k]) idx = 2'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/jtkunio_bram_arb.sv
// Bank request selector: one-hot grant from the request vector.
// JTKUNIO_BA_RR_EN: rotate priority after the last served bank; otherwise bank 0 wins.
module jtkunio_bram_arb
    import jtkunio_bram_ba_pkg::*;
(
    input  logic [NBANK-1:0] req,
`ifdef JTKUNIO_BA_RR_EN
    input  logic [1:0]       last,
`endif
    output logic [NBANK-1:0] grant
);

`ifdef JTKUNIO_BA_RR_EN
    // Walk from lowest to highest priority so the last hit is the winner
    always_comb begin
        logic [1:0] idx;
        grant = '0;
        idx   = '0;
        for (int k = NBANK; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) grant = NBANK'(1) << idx;
        end
    end
`else
    always_comb begin
        grant = '0;
        for (int k = NBANK - 1; k >= 0; k--) begin
            if (req[k]) grant = NBANK'(1) << k;
        end
    end
`endif

endmodule

// File: rtl/jtkunio_bram_ba.sv
// Replays the four-bank SDRAM and prog download handshakes on a single-port BRAM.
// JTKUNIO_BA_RR_EN enables round-robin bank selection (fixed priority otherwise). BURST must be 1..8.
module jtkunio_bram_ba
    import jtkunio_bram_ba_pkg::*;
#(
    parameter int AW    = 16,
    parameter int BURST = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             downloading,
    input  logic [CAW-1:0]   ba0_addr,
    input  logic [CAW-1:0]   ba1_addr,
    input  logic [CAW-1:0]   ba2_addr,
    input  logic [CAW-1:0]   ba3_addr,
    input  logic [NBANK-1:0] ba_rd,
    output logic [NBANK-1:0] ba_ack,
    output logic [NBANK-1:0] ba_dst,
    output logic [NBANK-1:0] ba_dok,
    output logic [NBANK-1:0] ba_rdy,
    output logic [DW-1:0]    data_read,
    input  logic [CAW-1:0]   prog_addr,
    input  logic [DW-1:0]    prog_data,
    input  logic [1:0]       prog_mask,
    input  logic [1:0]       prog_ba,
    input  logic             prog_we,
    input  logic             prog_rd,
    output logic             prog_ack,
    output logic             prog_dst,
    output logic             prog_dok,
    output logic             prog_rdy,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_din,
    output logic [1:0]       mem_be,
    output logic             mem_we,
    input  logic [DW-1:0]    mem_dout
);

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [1:0]       sel;
    logic [AW-3:0]    addr_q;
    logic [DW-1:0]    data_q;
    logic             capture;
    logic [NBANK-1:0] grant;
    logic [1:0]       gidx;
    logic [AW-3:0]    gaddr;
    logic             unused_bits;

    assign unused_bits = ^{ba0_addr[CAW-1:AW-2], ba1_addr[CAW-1:AW-2],
                           ba2_addr[CAW-1:AW-2], ba3_addr[CAW-1:AW-2],
                           prog_addr[CAW-1:AW-2]};

`ifdef JTKUNIO_BA_RR_EN
    logic [1:0] last;

    jtkunio_bram_arb u_arb (
        .req   (ba_rd),
        .last  (last),
        .grant (grant)
    );
`else
    jtkunio_bram_arb u_arb (
        .req   (ba_rd),
        .grant (grant)
    );
`endif

    assign gidx = onehot_idx(grant);

    always_comb begin
        gaddr = '0;
        case (gidx)
            2'd0:    gaddr = ba0_addr[AW-3:0];
            2'd1:    gaddr = ba1_addr[AW-3:0];
            2'd2:    gaddr = ba2_addr[AW-3:0];
            default: gaddr = ba3_addr[AW-3:0];
        endcase
    end

    // cnt counts cycles inside a state; in BREAD the address leads the data by one cycle
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 4'd1;
        ba_ack    = '0;
        ba_dst    = '0;
        ba_dok    = '0;
        ba_rdy    = '0;
        prog_ack  = 1'b0;
        prog_dst  = 1'b0;
        prog_dok  = 1'b0;
        prog_rdy  = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        mem_be    = '0;
        mem_we    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (prog_we)                      state_nxt = PWR;
                else if (prog_rd)                 state_nxt = PRD;
                else if (!downloading && |ba_rd)  state_nxt = BREAD;
            end
            BREAD: begin
                mem_addr = {sel, addr_q + (AW-2)'(cnt)};
                if (cnt == 4'd0) begin
                    ba_ack[sel] = 1'b1;
                end else begin
                    capture     = 1'b1;
                    ba_dok[sel] = 1'b1;
                    if (cnt == 4'd1)       ba_dst[sel] = 1'b1;
                    if (cnt == 4'(BURST))  ba_rdy[sel] = 1'b1;
                end
                if (cnt == 4'(BURST)) state_nxt = WAIT;
            end
            PWR: begin
                if (cnt == 4'd0) begin
                    prog_ack = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = {prog_ba, prog_addr[AW-3:0]};
                    mem_din  = prog_data;
                    mem_be   = ~prog_mask;
                end else begin
                    prog_rdy  = 1'b1;
                    state_nxt = WAIT;
                end
            end
            PRD: begin
                if (cnt == 4'd0) begin
                    prog_ack = 1'b1;
                    mem_addr = {prog_ba, prog_addr[AW-3:0]};
                end else begin
                    capture   = 1'b1;
                    prog_dst  = 1'b1;
                    prog_dok  = 1'b1;
                    prog_rdy  = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Memory data passes straight through while valid, then the register holds it
    assign data_read = capture ? mem_dout : data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sel    <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            data_q <= data_read;
            if (state == IDLE && state_nxt == BREAD) begin
                sel    <= gidx;
                addr_q <= gaddr;
            end
        end
    end

`ifdef JTKUNIO_BA_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 2'd3;
        end else if (state == IDLE && state_nxt == BREAD) begin
            last <= gidx;
        end
    end
`endif

endmodule
